// File: rtl/pcore_interface_defs.sv
// Shared IF-stage definitions: fetch-word and aligned-instruction bundles plus
// the instruction-length encoding used by the fetch aligner.
package pcore_interface_defs;

  localparam int         IF_PC_W     = 32;
  localparam logic [1:0] INST_LEN_32 = 2'b11;

  typedef struct packed {
    logic [31:0]        data;
    logic [IF_PC_W-1:0] pc;
    logic               valid;
  } type_if_fetch_s;

  typedef struct packed {
    logic [31:0]        inst;
    logic [IF_PC_W-1:0] pc;
    logic               comp;
    logic               valid;
  } type_if_inst_s;

  // Which part of the buffered state feeds the decoder this cycle.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_STRADDLE,
    SEL_LOW16,
    SEL_LOW32,
    SEL_HIGH16,
    SEL_HIGH_SPLIT
  } sel_e;

  function automatic logic is_comp(input logic [15:0] hw);
    return hw[1:0] != INST_LEN_32;
  endfunction

endpackage

// File: rtl/fetch_align_sel.sv
// Priority selector: picks the next instruction from the word buffer and
// residual halfword, and reports what a handshake would do to that state.
module fetch_align_sel
  import pcore_interface_defs::*;
#(
  parameter int PC_W = 32
) (
  input  logic            wb_valid_i,
  input  logic [31:0]     wb_data_i,
  input  logic [PC_W-1:0] wb_pc_i,
  input  logic            wb_off_i,
  input  logic            res_valid_i,
  input  logic [15:0]     res_data_i,
  input  logic [PC_W-1:0] res_pc_i,
  output logic            valid_o,
  output logic [31:0]     inst_o,
  output logic [PC_W-1:0] pc_o,
  output logic            comp_o,
  output logic            consume_hs_o,
  output logic            advance_hs_o,
  output logic            clear_res_hs_o,
  output logic            split_o
);

  sel_e sel;

  always_comb begin
    sel = SEL_NONE;
    if (wb_valid_i) begin
      if (res_valid_i)    sel = SEL_STRADDLE;
      else if (!wb_off_i) sel = is_comp(wb_data_i[15:0])  ? SEL_LOW16  : SEL_LOW32;
      else                sel = is_comp(wb_data_i[31:16]) ? SEL_HIGH16 : SEL_HIGH_SPLIT;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    valid_o        = 1'b0;
    inst_o         = '0;
    pc_o           = '0;
    comp_o         = 1'b0;
    consume_hs_o   = 1'b0;
    advance_hs_o   = 1'b0;
    clear_res_hs_o = 1'b0;
    split_o        = 1'b0;
    unique case (sel)
      SEL_STRADDLE: begin
        valid_o        = 1'b1;
        inst_o         = {wb_data_i[15:0], res_data_i};
        pc_o           = res_pc_i;
        clear_res_hs_o = 1'b1;
        advance_hs_o   = 1'b1;
      end
      SEL_LOW16: begin
        valid_o      = 1'b1;
        inst_o       = {16'h0, wb_data_i[15:0]};
        pc_o         = wb_pc_i;
        comp_o       = 1'b1;
        advance_hs_o = 1'b1;
      end
      SEL_LOW32: begin
        valid_o      = 1'b1;
        inst_o       = wb_data_i;
        pc_o         = wb_pc_i;
        consume_hs_o = 1'b1;
      end
      SEL_HIGH16: begin
        valid_o      = 1'b1;
        inst_o       = {16'h0, wb_data_i[31:16]};
        pc_o         = wb_pc_i + PC_W'(2);
        comp_o       = 1'b1;
        consume_hs_o = 1'b1;
      end
      // Upper half opens a 32-bit instruction: park it, no output this cycle.
      SEL_HIGH_SPLIT: split_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_align.sv
// IF-stage fetch aligner: turns word-aligned fetch words into one 16/32-bit
// instruction per handshake, handling straddles and halfword redirects.
module fetch_align
  import pcore_interface_defs::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fw_valid,
  output logic            fw_ready,
  input  logic [31:0]     fw_data,
  input  logic [PC_W-1:0] fw_pc,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_inst,
  output logic [PC_W-1:0] if_pc,
  output logic            if_comp
);

  logic            wb_valid_q, wb_valid_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [PC_W-1:0] wb_pc_q, wb_pc_d;
  logic            wb_off_q, wb_off_d;
  logic            res_valid_q, res_valid_d;
  logic [15:0]     res_data_q, res_data_d;
  logic [PC_W-1:0] res_pc_q, res_pc_d;
  logic            skip_low_q, skip_low_d;

  logic            sel_valid, sel_comp;
  logic [31:0]     sel_inst;
  logic [PC_W-1:0] sel_pc;
  logic            consume_hs, advance_hs, clear_res_hs, split;
  logic            hs, consume, accept;
  logic            flush_pc_unused;

  fetch_align_sel #(.PC_W(PC_W)) u_sel (
    .wb_valid_i     (wb_valid_q),
    .wb_data_i      (wb_data_q),
    .wb_pc_i        (wb_pc_q),
    .wb_off_i       (wb_off_q),
    .res_valid_i    (res_valid_q),
    .res_data_i     (res_data_q),
    .res_pc_i       (res_pc_q),
    .valid_o        (sel_valid),
    .inst_o         (sel_inst),
    .pc_o           (sel_pc),
    .comp_o         (sel_comp),
    .consume_hs_o   (consume_hs),
    .advance_hs_o   (advance_hs),
    .clear_res_hs_o (clear_res_hs),
    .split_o        (split)
  );

  assign if_valid = sel_valid & ~flush;
  assign if_inst  = sel_inst;
  assign if_pc    = sel_pc;
  assign if_comp  = sel_comp;

  assign hs       = if_valid & if_ready;
  assign consume  = (hs & consume_hs) | split;
  assign fw_ready = ~flush & (~wb_valid_q | consume);
  assign accept   = fw_valid & fw_ready;

  // Only bit 1 of a redirect target matters; fetch words are word aligned.
  assign flush_pc_unused = ^{flush_pc[PC_W-1:2], flush_pc[0]};

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_data_d   = wb_data_q;
    wb_pc_d     = wb_pc_q;
    wb_off_d    = wb_off_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_pc_d    = res_pc_q;
    skip_low_d  = skip_low_q;
    if (flush) begin
      wb_valid_d  = 1'b0;
      res_valid_d = 1'b0;
      skip_low_d  = flush_pc[1];
    end else begin
      if (hs && advance_hs)   wb_off_d    = 1'b1;
      if (hs && clear_res_hs) res_valid_d = 1'b0;
      if (split) begin
        res_valid_d = 1'b1;
        res_data_d  = wb_data_q[31:16];
        res_pc_d    = wb_pc_q + PC_W'(2);
      end
      if (consume) wb_valid_d = 1'b0;
      if (accept) begin
        wb_valid_d = 1'b1;
        wb_data_d  = fw_data;
        wb_pc_d    = fw_pc;
        wb_off_d   = skip_low_q;
        skip_low_d = 1'b0;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments; payload registers are
  // reset too so the outputs read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_pc_q     <= '0;
      wb_off_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_pc_q    <= '0;
      skip_low_q  <= 1'b0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_pc_q     <= wb_pc_d;
      wb_off_q    <= wb_off_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_pc_q    <= res_pc_d;
      skip_low_q  <= skip_low_d;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: directed per-cycle scenarios plus a randomized run
// checked against a halfword-stream model of the instruction sequence.
module tb_fetch_align;
  import pcore_interface_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fw_valid, fw_ready, flush, if_valid, if_ready, if_comp;
  logic [31:0] fw_data, fw_pc, flush_pc, if_inst, if_pc;

  int n_cmp = 0;
  int n_err = 0;

  type_if_inst_s obs;
  logic          obs_ready;

  typedef struct {
    logic        fv;
    logic [31:0] fd;
    logic [31:0] fp;
    logic        fl;
    logic [31:0] flp;
    logic        ir;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        ec;
    logic        er;
  } vec_t;

  typedef struct packed {
    logic [15:0] hw;
    logic [31:0] pc;
  } hw_t;

  fetch_align #(.PC_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fw_valid (fw_valid),
    .fw_ready (fw_ready),
    .fw_data  (fw_data),
    .fw_pc    (fw_pc),
    .flush    (flush),
    .flush_pc (flush_pc),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_inst  (if_inst),
    .if_pc    (if_pc),
    .if_comp  (if_comp)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fv, input logic [31:0] fd, input logic [31:0] fp,
                              input logic fl, input logic [31:0] flp, input logic ir,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                              input logic ec, input logic er);
    vec_t v;
    v.fv = fv; v.fd = fd; v.fp = fp; v.fl = fl; v.flp = flp; v.ir = ir;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.er = er;
    return v;
  endfunction

  // Drive one cycle's inputs, sample outputs at the falling edge, then move
  // just past the next rising edge.
  task automatic apply(input vec_t v);
    fw_valid = v.fv; fw_data = v.fd; fw_pc = v.fp;
    flush = v.fl; flush_pc = v.flp; if_ready = v.ir;
    @(negedge clk);
    obs.valid = if_valid; obs.inst = if_inst; obs.pc = if_pc; obs.comp = if_comp;
    obs_ready = fw_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fw_valid = 1'b0; fw_data = '0; fw_pc = '0; flush = 1'b0; flush_pc = '0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({if_valid, if_inst, if_pc, if_comp} !== 66'b0) begin
      n_err++;
      $display("FAIL reset: got v=%b inst=%h pc=%h c=%b, want all zero", if_valid, if_inst, if_pc, if_comp);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_two_compressed();
    vec_t v[$];
    v.push_back(mk(1, 32'h4505_4501, 32'h100, 0, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0000_4501, 32'h100, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0000_4505, 32'h102, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]);
      n_cmp++;
      if (obs.valid !== v[i].ev || obs_ready !== v[i].er ||
          (v[i].ev && (obs.inst !== v[i].ei || obs.pc !== v[i].ep || obs.comp !== v[i].ec))) begin
        n_err++;
        $display("FAIL two_comp[%0d]: got v=%b rdy=%b inst=%h pc=%h c=%b, want v=%b rdy=%b inst=%h pc=%h c=%b",
                 i, obs.valid, obs_ready, obs.inst, obs.pc, obs.comp, v[i].ev, v[i].er, v[i].ei, v[i].ep, v[i].ec);
      end
    end
  endtask

  task automatic test_aligned32();
    vec_t v[$];
    v.push_back(mk(1, 32'h00A0_0513, 32'h200, 0, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h00A0_0513, 32'h200, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]);
      n_cmp++;
      if (obs.valid !== v[i].ev || obs_ready !== v[i].er ||
          (v[i].ev && (obs.inst !== v[i].ei || obs.pc !== v[i].ep || obs.comp !== v[i].ec))) begin
        n_err++;
        $display("FAIL aligned32[%0d]: got v=%b rdy=%b inst=%h pc=%h c=%b, want v=%b rdy=%b inst=%h pc=%h c=%b",
                 i, obs.valid, obs_ready, obs.inst, obs.pc, obs.comp, v[i].ev, v[i].er, v[i].ei, v[i].ep, v[i].ec);
      end
    end
  endtask

  task automatic test_straddle();
    vec_t v[$];
    v.push_back(mk(1, 32'h0513_4501, 32'h300, 0, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 32'h4505_00A0, 32'h304, 0, 0, 1, 1, 32'h0000_4501, 32'h300, 1, 0));
    v.push_back(mk(1, 32'h4505_00A0, 32'h304, 0, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h00A0_0513, 32'h302, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0000_4505, 32'h306, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]);
      n_cmp++;
      if (obs.valid !== v[i].ev || obs_ready !== v[i].er ||
          (v[i].ev && (obs.inst !== v[i].ei || obs.pc !== v[i].ep || obs.comp !== v[i].ec))) begin
        n_err++;
        $display("FAIL straddle[%0d]: got v=%b rdy=%b inst=%h pc=%h c=%b, want v=%b rdy=%b inst=%h pc=%h c=%b",
                 i, obs.valid, obs_ready, obs.inst, obs.pc, obs.comp, v[i].ev, v[i].er, v[i].ei, v[i].ep, v[i].ec);
      end
    end
  endtask

  task automatic test_redirect();
    vec_t v[$];
    v.push_back(mk(1, 32'hFFFF_FFFF, 32'h3F0, 1, 32'h402, 1, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 32'h4585_4501, 32'h400, 0, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0000_4585, 32'h402, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]);
      n_cmp++;
      if (obs.valid !== v[i].ev || obs_ready !== v[i].er ||
          (v[i].ev && (obs.inst !== v[i].ei || obs.pc !== v[i].ep || obs.comp !== v[i].ec))) begin
        n_err++;
        $display("FAIL redirect[%0d]: got v=%b rdy=%b inst=%h pc=%h c=%b, want v=%b rdy=%b inst=%h pc=%h c=%b",
                 i, obs.valid, obs_ready, obs.inst, obs.pc, obs.comp, v[i].ev, v[i].er, v[i].ei, v[i].ep, v[i].ec);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t v[$];
    v.push_back(mk(1, 32'h0513_4501, 32'h300, 0, 0, 1, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++)
      v.push_back(mk(1, 32'h4505_00A0, 32'h304, 0, 0, 0, 1, 32'h0000_4501, 32'h300, 1, 0));
    v.push_back(mk(1, 32'h4505_00A0, 32'h304, 0, 0, 1, 1, 32'h0000_4501, 32'h300, 1, 0));
    v.push_back(mk(1, 32'h4505_00A0, 32'h304, 0, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h00A0_0513, 32'h302, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h00A0_0513, 32'h302, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0000_4505, 32'h306, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]);
      n_cmp++;
      if (obs.valid !== v[i].ev || obs_ready !== v[i].er ||
          (v[i].ev && (obs.inst !== v[i].ei || obs.pc !== v[i].ep || obs.comp !== v[i].ec))) begin
        n_err++;
        $display("FAIL backpressure[%0d]: got v=%b rdy=%b inst=%h pc=%h c=%b, want v=%b rdy=%b inst=%h pc=%h c=%b",
                 i, obs.valid, obs_ready, obs.inst, obs.pc, obs.comp, v[i].ev, v[i].er, v[i].ei, v[i].ep, v[i].ec);
      end
    end
  endtask

  task automatic test_reset_mid_straddle();
    vec_t v[$];
    apply(mk(1, 32'h0513_4501, 32'h300, 0, 0, 1, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Low half goes out; next cycle parks 0x0513 and takes the second word.
    apply(mk(1, 32'h4505_00A0, 32'h304, 0, 0, 1, 0, 0, 0, 0, 0));
    fw_valid = 1'b0; if_ready = 1'b0;
    #1;
    n_cmp++;
    if (if_valid !== 1'b1 || if_inst !== 32'h00A0_0513) begin
      n_err++;
      $display("FAIL pre_reset_straddle: got v=%b inst=%h, want v=1 inst=00a00513", if_valid, if_inst);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if_valid, if_inst, if_pc, if_comp} !== 66'b0) begin
      n_err++;
      $display("FAIL reset_mid_straddle: got v=%b inst=%h pc=%h c=%b, want all zero", if_valid, if_inst, if_pc, if_comp);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v.push_back(mk(1, 32'h00A0_0513, 32'h000, 0, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h00A0_0513, 32'h000, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]);
      n_cmp++;
      if (obs.valid !== v[i].ev || obs_ready !== v[i].er ||
          (v[i].ev && (obs.inst !== v[i].ei || obs.pc !== v[i].ep || obs.comp !== v[i].ec))) begin
        n_err++;
        $display("FAIL after_reset[%0d]: got v=%b rdy=%b inst=%h pc=%h c=%b, want v=%b rdy=%b inst=%h pc=%h c=%b",
                 i, obs.valid, obs_ready, obs.inst, obs.pc, obs.comp, v[i].ev, v[i].er, v[i].ei, v[i].ep, v[i].ec);
      end
    end
  endtask

  // Model: accepted words become a halfword stream; instructions are parsed
  // from the head of that stream in program order.
  task automatic test_random();
    hw_t         q[$];
    logic        skip;
    logic [31:0] npc, cur_d, exp_i, exp_p;
    logic        exp_c;
    int          emitted;
    skip = 1'b0; npc = 32'h1000; cur_d = $urandom; emitted = 0;
    for (int c = 0; c < 1508; c++) begin
      logic        fv_r, fl_r, ir_r;
      logic [31:0] flp_r;
      bit          drain;
      drain = (c >= 1500);
      fv_r  = !drain && ($urandom_range(0, 9) < 7);
      ir_r  = drain || ($urandom_range(0, 9) < 7);
      fl_r  = !drain && ($urandom_range(0, 49) == 0);
      flp_r = 32'($urandom_range(0, 1023)) << 1;
      apply(mk(fv_r, cur_d, npc, fl_r, flp_r, ir_r, 0, 0, 0, 0, 0));
      if (obs.valid && ir_r) begin
        n_cmp++;
        emitted++;
        if (q.size() == 0 || (q[0].hw[1:0] == 2'b11 && q.size() < 2)) begin
          n_err++;
          $display("FAIL random_unexpected: got inst=%h pc=%h c=%b, want no instruction", obs.inst, obs.pc, obs.comp);
        end else begin
          exp_p = q[0].pc;
          if (q[0].hw[1:0] != 2'b11) begin
            exp_i = {16'h0, q[0].hw}; exp_c = 1'b1;
            void'(q.pop_front());
          end else begin
            exp_i = {q[1].hw, q[0].hw}; exp_c = 1'b0;
            void'(q.pop_front());
            void'(q.pop_front());
          end
          if (obs.inst !== exp_i || obs.pc !== exp_p || obs.comp !== exp_c) begin
            n_err++;
            $display("FAIL random_inst: got inst=%h pc=%h c=%b, want inst=%h pc=%h c=%b",
                     obs.inst, obs.pc, obs.comp, exp_i, exp_p, exp_c);
          end
        end
      end
      if (fl_r) begin
        q.delete();
        skip  = flp_r[1];
        npc   = flp_r & ~32'h3;
        cur_d = $urandom;
      end else if (fv_r && obs_ready) begin
        if (!skip) q.push_back('{hw: cur_d[15:0], pc: npc});
        q.push_back('{hw: cur_d[31:16], pc: npc + 32'd2});
        skip  = 1'b0;
        npc   = npc + 32'd4;
        cur_d = $urandom;
      end
    end
    n_cmp++;
    if (!(q.size() == 0 || (q.size() == 1 && q[0].hw[1:0] == 2'b11))) begin
      n_err++;
      $display("FAIL random_drain: got %0d halfwords left unissued, want at most one pending 32-bit start", q.size());
    end
    n_cmp++;
    if (emitted < 100) begin
      n_err++;
      $display("FAIL random_throughput: got %0d instructions, want at least 100", emitted);
    end
  endtask

  initial begin
    test_reset();
    test_two_compressed();
    test_aligned32();
    test_straddle();
    test_redirect();
    test_backpressure();
    test_reset_mid_straddle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_align.md
Name: fetch_align

Overview:
- Sits between the instruction-memory fetch port and the compressed-instruction expander/decoder in the IF stage.
- Accepts word-aligned 32-bit fetch words and emits exactly one instruction per handshake, with its exact PC and a 16-bit flag.
- Handles mixed 16/32-bit streams, 32-bit instructions straddling two fetch words, and redirects to halfword-aligned targets.
- Downstream logic never needs halfword selection or misalignment bookkeeping.

Parameters:
- PC_W, 32, width of all PC/address fields.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- fw_valid  in  1  fetch word valid.
- fw_ready  out  1  block can accept a fetch word.
- fw_data  in  32  fetch word, little-endian halfwords.
- fw_pc  in  PC_W  address of fw_data; bits [1:0] are always 0.
- flush  in  1  redirect: discard all buffered state.
- flush_pc  in  PC_W  redirect target; bit 0 is always 0.
- if_valid  out  1  instruction valid.
- if_ready  in  1  consumer accepts the instruction.
- if_inst  out  32  instruction; for 16-bit instructions it is {16'h0, halfword}.
- if_pc  out  PC_W  PC of if_inst.
- if_comp  out  1  1 = 16-bit instruction (bits [1:0] != 2'b11).

Behaviour:
- State registers:
  - Word buffer: wb_valid, wb_data, wb_pc, wb_off (0 = low half next, 1 = high half next).
  - Residual halfword: res_valid, res_data, res_pc.
  - skip_low: applied to the next accepted word.
- Reset: all valid flags 0, skip_low 0, wb_off 0. Outputs if_valid=0, if_inst=0, if_pc=0, if_comp=0.
- Output selection, combinational from registers (priority order):
  1. res_valid & wb_valid: if_inst={wb_data[15:0],res_data}, if_pc=res_pc, if_comp=0. Handshake clears res_valid and sets wb_off=1.
  2. !res_valid & wb_valid & wb_off=0, wb_data[1:0]!=11: if_inst={16'h0,wb_data[15:0]}, if_pc=wb_pc, if_comp=1. Handshake sets wb_off=1.
  3. !res_valid & wb_valid & wb_off=0, wb_data[1:0]==11: if_inst=wb_data, if_pc=wb_pc, if_comp=0. Handshake consumes the word.
  4. wb_valid & wb_off=1, wb_data[17:16]!=11: if_inst={16'h0,wb_data[31:16]}, if_pc=wb_pc+2, if_comp=1. Handshake consumes the word.
  5. wb_valid & wb_off=1, wb_data[17:16]==11: if_valid=0. Unconditionally move the high half to the residual (res_pc=wb_pc+2) and consume the word.
- Halfword 16'h0000 is passed through as a 16-bit instruction; the decoder raises illegal.
- Latency: a word accepted in cycle N is presentable in cycle N+1. A straddled instruction is presentable the cycle after its second word is accepted.
- fw_ready = !flush & (!wb_valid | word consumed this cycle). On acceptance, wb_off=skip_low, then skip_low is cleared.
- Fetch words are sequential (+4) between flushes; no check is performed.
- Backpressure: while if_valid & !if_ready, if_inst, if_pc and if_comp hold stable.
- Flush: if_valid is forced 0 in the flush cycle and any if_ready in that cycle is ignored. The fetch word presented in that cycle is dropped. Next cycle: wb_valid=0, res_valid=0, skip_low=flush_pc[1].
- Flush and reset take effect mid-straddle; the residual is discarded.

Decomposition:
- Shared package (pcore_interface_defs): add the fetch-word struct type_if_fetch_s {data, pc, valid} and the aligned-instruction struct type_if_inst_s {inst, pc, comp, valid}.
- Add localparam INST_LEN_32 = 2'b11 to the package.
- One natural sub-module: fetch_align_sel, a combinational priority selector producing if_* fields and consume/advance strobes from the buffer state.

Test Plan:
- Two 16-bit in one word: word 0x4505_4501 at pc 0x100, if_ready=1 → 0x00004501 @0x100 comp=1, then 0x00004505 @0x102 comp=1; fw_ready re-asserts in the second output cycle.
- Aligned 32-bit: 0x00A00513 at 0x200 → single output 0x00A00513 @0x200 comp=0, one cycle after acceptance.
- Straddle: 0x0513_4501 at 0x300, then 0x4505_00A0 at 0x304 → 0x00004501 @0x300, then 0x00A00513 @0x302 comp=0, then 0x00004505 @0x306.
- Halfword redirect: flush with flush_pc=0x402, then word 0x4585_4501 at 0x400 → only 0x00004585 @0x402; the low half is never emitted.
- Backpressure: hold if_ready=0 for 3 cycles during the straddle case → if_* stable; fw_ready=0 once a word is buffered; the output sequence is unchanged after release.
- Reset mid-straddle: residual 0x0513 held, assert rst_n low → if_valid=0 immediately. After release, word 0x00A00513 at 0x000 is emitted whole, with no stale residual.
